// File: rtl/uart_tx_frame_if.sv
// Host-side handshake bundle for uart_tx_frame: the offered word and the FIFO-ready reply.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_TxValid;
    logic [DATA_BITS-1:0] i_TxData;
    logic                 o_TxReady;

    modport master (output i_TxValid, output i_TxData, input  o_TxReady);
    modport slave  (input  i_TxValid, input  i_TxData, output o_TxReady);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a transmit FIFO behind a valid/ready handshake.
// Frames are start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits.
module uart_tx_frame #(
    parameter int  SYS_CLOCK     = 50000000,
    parameter int  UART_BAUDRATE = 115200,
    parameter int  DATA_BITS     = 8,
    parameter int  PARITY        = 0,
    parameter int  STOP_BITS     = 1,
    parameter int  FIFO_DEPTH    = 16,
    localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_SysClock,
    input  logic          i_ResetN,
    uart_tx_frame_if.slave txIf,
    output logic          o_TxSerial,
    output logic          o_TxBusy,
    output logic          o_TxDone,
    output logic [CW-1:0] o_FifoCount
);

    localparam int CLKS_PER_BIT = SYS_CLOCK / UART_BAUDRATE;
    localparam int CNTW         = $clog2(CLKS_PER_BIT);
    localparam int IDXW         = $clog2(DATA_BITS);
    localparam int PW           = $clog2(FIFO_DEPTH);

    localparam logic [CNTW-1:0] LAST_TICK = CNTW'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DATA_BITS - 1);
    localparam logic            LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);

    if (PARITY < 0 || PARITY > 2) begin : gBadParity
        $error("uart_tx_frame: illegal PARITY mode %0d", PARITY);
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } txState_t;

    logic [DATA_BITS-1:0] fifoMem [FIFO_DEPTH];
    logic [PW-1:0]        wrPtr;
    logic [PW-1:0]        rdPtr;
    logic [CW-1:0]        fifoCount;
    logic [CW-1:0]        countNext;
    logic                 txReady;
    logic                 fifoEmpty;
    logic                 doPush;
    logic                 doPop;
    logic [DATA_BITS-1:0] headWord;
    logic                 headParity;

    txState_t             state;
    txState_t             stateNext;
    logic [CNTW-1:0]      clkCnt;
    logic [CNTW-1:0]      clkCntNext;
    logic [IDXW-1:0]      bitIdx;
    logic [IDXW-1:0]      bitIdxNext;
    logic                 stopIdx;
    logic                 stopIdxNext;
    logic [DATA_BITS-1:0] shiftReg;
    logic [DATA_BITS-1:0] shiftNext;
    logic                 parityReg;
    logic                 parityNext;
    logic                 serialReg;
    logic                 serialNext;
    logic                 doneReg;
    logic                 doneNext;
    logic                 lastTick;
    logic                 loadFrame;

    // Ready is registered from the post-edge count, so a full FIFO rejects a write even on a pop edge.
    assign doPush     = txIf.i_TxValid && txReady;
    assign fifoEmpty  = (fifoCount == '0);
    assign headWord   = fifoMem[rdPtr];
    assign headParity = (PARITY == 1) ? ~^headWord : ^headWord;
    assign lastTick   = (clkCnt == LAST_TICK);

    always_ff @(posedge i_SysClock) begin
        if (doPush) begin
            fifoMem[wrPtr] <= txIf.i_TxData;
        end
    end

    always_comb begin
        countNext = fifoCount;
        if (doPush && !doPop) begin
            countNext = fifoCount + 1'b1;
        end else if (!doPush && doPop) begin
            countNext = fifoCount - 1'b1;
        end
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            txReady   <= 1'b1;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            fifoCount <= countNext;
            txReady   <= (countNext < DEPTH_C);
        end
    end

    always_ff @(posedge i_SysClock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state     <= ST_IDLE;
            clkCnt    <= '0;
            bitIdx    <= '0;
            stopIdx   <= 1'b0;
            shiftReg  <= '0;
            parityReg <= 1'b0;
            serialReg <= 1'b1;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            clkCnt    <= clkCntNext;
            bitIdx    <= bitIdxNext;
            stopIdx   <= stopIdxNext;
            shiftReg  <= shiftNext;
            parityReg <= parityNext;
            serialReg <= serialNext;
            doneReg   <= doneNext;
        end
    end

    // The line level is registered, so each branch sets the level the next state will drive.
    always_comb begin
        stateNext   = state;
        clkCntNext  = clkCnt;
        bitIdxNext  = bitIdx;
        stopIdxNext = stopIdx;
        shiftNext   = shiftReg;
        parityNext  = parityReg;
        serialNext  = serialReg;
        doneNext    = 1'b0;
        loadFrame   = 1'b0;
        doPop       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                serialNext = 1'b1;
                if (!fifoEmpty) begin
                    loadFrame = 1'b1;
                end
            end
            ST_START: begin
                if (lastTick) begin
                    stateNext  = ST_DATA;
                    clkCntNext = '0;
                    bitIdxNext = '0;
                    serialNext = shiftReg[0];
                end else begin
                    clkCntNext = clkCnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (lastTick) begin
                    clkCntNext = '0;
                    if (bitIdx == LAST_IDX) begin
                        if (PARITY != 0) begin
                            stateNext  = ST_PARITY;
                            serialNext = parityReg;
                        end else begin
                            stateNext   = ST_STOP;
                            stopIdxNext = 1'b0;
                            serialNext  = 1'b1;
                        end
                    end else begin
                        bitIdxNext = bitIdx + 1'b1;
                        shiftNext  = shiftReg >> 1;
                        serialNext = shiftReg[1];
                    end
                end else begin
                    clkCntNext = clkCnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (lastTick) begin
                    stateNext   = ST_STOP;
                    clkCntNext  = '0;
                    stopIdxNext = 1'b0;
                    serialNext  = 1'b1;
                end else begin
                    clkCntNext = clkCnt + 1'b1;
                end
            end
            ST_STOP: begin
                serialNext = 1'b1;
                if (lastTick) begin
                    clkCntNext = '0;
                    if (stopIdx == LAST_STOP) begin
                        doneNext = 1'b1;
                        if (!fifoEmpty) begin
                            loadFrame = 1'b1;
                        end else begin
                            stateNext = ST_IDLE;
                        end
                    end else begin
                        stopIdxNext = stopIdx + 1'b1;
                    end
                end else begin
                    clkCntNext = clkCnt + 1'b1;
                end
            end
            default: begin
                stateNext  = ST_IDLE;
                serialNext = 1'b1;
            end
        endcase

        // Shared by the idle start and the back-to-back start so both begin a frame identically.
        if (loadFrame) begin
            doPop      = 1'b1;
            stateNext  = ST_START;
            clkCntNext = '0;
            shiftNext  = headWord;
            parityNext = headParity;
            serialNext = 1'b0;
        end
    end

    assign txIf.o_TxReady = txReady;
    assign o_TxSerial     = serialReg;
    assign o_TxBusy       = (state != ST_IDLE);
    assign o_TxDone       = doneReg;
    assign o_FifoCount    = fifoCount;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8N1 depth 4, 7E2, 7O2) checked against a frame-level model.
module tb_uart_tx_frame;

    localparam int CPB    = 10;
    localparam int NDUT   = 3;
    localparam int PERIOD = 10;

    typedef struct {
        int         dut;
        logic [8:0] word;
        logic [11:0] expBits;
        int         expLen;
    } frameVec_t;

    int cfgDataBits [NDUT] = '{8, 7, 7};
    int cfgParity   [NDUT] = '{0, 2, 1};
    int cfgStop     [NDUT] = '{1, 2, 2};
    int cfgDepth    [NDUT] = '{4, 16, 16};

    logic       clock;
    logic       resetN;
    logic [2:0] validW;
    logic [8:0] dataW [NDUT];
    logic [2:0] serialW;
    logic [2:0] busyW;
    logic [2:0] doneW;
    logic [2:0] readyW;
    logic [2:0] countA;
    logic [4:0] countB;
    logic [4:0] countC;
    logic       checkEn;

    int total;
    int bad;

    int         mCnt  [NDUT];
    int         mRem  [NDUT];
    int         mHead [NDUT];
    int         mTail [NDUT];
    logic [8:0] mQ    [NDUT][16];
    logic [8:0] mCur  [NDUT];
    logic       mDone [NDUT];

    time doneTimes[$];

    uart_tx_frame_if #(.DATA_BITS(8)) ifA ();
    uart_tx_frame_if #(.DATA_BITS(7)) ifB ();
    uart_tx_frame_if #(.DATA_BITS(7)) ifC ();

    assign ifA.i_TxValid = validW[0];
    assign ifA.i_TxData  = dataW[0][7:0];
    assign ifB.i_TxValid = validW[1];
    assign ifB.i_TxData  = dataW[1][6:0];
    assign ifC.i_TxValid = validW[2];
    assign ifC.i_TxData  = dataW[2][6:0];
    assign readyW        = {ifC.o_TxReady, ifB.o_TxReady, ifA.o_TxReady};

    uart_tx_frame #(.SYS_CLOCK(1000), .UART_BAUDRATE(100), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) dutA (
        .i_SysClock(clock), .i_ResetN(resetN), .txIf(ifA),
        .o_TxSerial(serialW[0]), .o_TxBusy(busyW[0]), .o_TxDone(doneW[0]), .o_FifoCount(countA));

    uart_tx_frame #(.SYS_CLOCK(1000), .UART_BAUDRATE(100), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(16)) dutB (
        .i_SysClock(clock), .i_ResetN(resetN), .txIf(ifB),
        .o_TxSerial(serialW[1]), .o_TxBusy(busyW[1]), .o_TxDone(doneW[1]), .o_FifoCount(countB));

    uart_tx_frame #(.SYS_CLOCK(1000), .UART_BAUDRATE(100), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(16)) dutC (
        .i_SysClock(clock), .i_ResetN(resetN), .txIf(ifC),
        .o_TxSerial(serialW[2]), .o_TxBusy(busyW[2]), .o_TxDone(doneW[2]), .o_FifoCount(countC));

    initial begin
        clock = 1'b0;
        forever #(PERIOD / 2) clock = ~clock;
    end

    function automatic int frameLen(input int d);
        return 1 + cfgDataBits[d] + ((cfgParity[d] != 0) ? 1 : 0) + cfgStop[d];
    endfunction

    // Line level of bit idx (0 = start) for word w under configuration d.
    function automatic logic frameBit(input int d, input logic [8:0] w, input int idx);
        int         nb;
        int         ones;
        logic [8:0] mask;
        nb   = cfgDataBits[d];
        mask = 9'h1FF >> (9 - nb);
        ones = $countones(w & mask);
        if (idx == 0) return 1'b0;
        if (idx <= nb) return w[idx-1];
        if (cfgParity[d] != 0 && idx == nb + 1) begin
            if (cfgParity[d] == 1) return ((ones % 2) == 0);
            return ((ones % 2) == 1);
        end
        return 1'b1;
    endfunction

    function automatic logic [7:0] getCount(input int d);
        if (d == 0) return 8'(countA);
        if (d == 1) return 8'(countB);
        return 8'(countC);
    endfunction

    function automatic logic [11:0] actVec(input int d);
        return {serialW[d], busyW[d], doneW[d], readyW[d], getCount(d)};
    endfunction

    function automatic logic expLine(input int d);
        if (mRem[d] > 0) return frameBit(d, mCur[d], (frameLen(d) * CPB - mRem[d]) / CPB);
        return 1'b1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [8:0] word);
        @(negedge clock);
        validW[d] = 1'b1;
        dataW[d]  = word;
        @(negedge clock);
        validW[d] = 1'b0;
    endtask

    // Waits for the start bit, samples each bit mid-period and times the done pulse from the start edge.
    task automatic checkFrame(input int d, input logic [11:0] expBits, input int expLen, input string tag);
        bit          found;
        logic [11:0] got;
        int          doneAt;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (serialW[d] == 1'b0) found = 1'b1;
            else @(negedge clock);
        end
        checkOutput({tag, " start seen"}, 32'(found), 32'd1);
        if (!found) return;
        got    = '0;
        doneAt = -1;
        for (int c = 0; c <= expLen * CPB + 2; c++) begin
            if ((c % CPB) == 5 && (c / CPB) < expLen) got[c / CPB] = serialW[d];
            if (doneW[d] && doneAt < 0) doneAt = c;
            @(negedge clock);
        end
        checkOutput({tag, " bits"}, 32'(got), 32'(expBits));
        checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(expLen * CPB));
    endtask

    // Frame-level reference: one timer per frame, popping a queued word whenever the line is free or just freeing.
    initial begin
        forever begin
            @(posedge clock);
            for (int d = 0; d < NDUT; d++) begin
                bit pushOk;
                bit popOk;
                if (!resetN) begin
                    mCnt[d]  = 0;
                    mRem[d]  = 0;
                    mHead[d] = 0;
                    mTail[d] = 0;
                    mDone[d] = 1'b0;
                    mCur[d]  = '0;
                end else begin
                    pushOk   = validW[d] && (mCnt[d] < cfgDepth[d]);
                    popOk    = (mCnt[d] > 0) && (mRem[d] <= 1);
                    mDone[d] = (mRem[d] == 1);
                    if (popOk) begin
                        mCur[d]  = mQ[d][mHead[d]];
                        mHead[d] = (mHead[d] + 1) % 16;
                        mRem[d]  = frameLen(d) * CPB;
                    end else if (mRem[d] > 0) begin
                        mRem[d] = mRem[d] - 1;
                    end
                    if (pushOk) begin
                        mQ[d][mTail[d]] = dataW[d];
                        mTail[d] = (mTail[d] + 1) % 16;
                    end
                    mCnt[d] = mCnt[d] + (pushOk ? 1 : 0) - (popOk ? 1 : 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (resetN && checkEn) begin
                for (int d = 0; d < NDUT; d++) begin
                    logic [11:0] expV;
                    expV = {expLine(d), (mRem[d] > 0), mDone[d], (mCnt[d] < cfgDepth[d]), 8'(mCnt[d])};
                    checkOutput($sformatf("cycle dut%0d t=%0t", d, $time), 32'(actVec(d)), 32'(expV));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (resetN && doneW[0]) doneTimes.push_back($time);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frameVec_t   vecs [9];
        logic [8:0]  fillWords [6];
        logic [7:0]  prevCount;
        bit          changed;

        vecs[0] = '{0, 9'h055, 12'h2AA, 10};
        vecs[1] = '{0, 9'h0A3, 12'h346, 10};
        vecs[2] = '{1, 9'h007, 12'h70E, 11};
        vecs[3] = '{2, 9'h007, 12'h60E, 11};
        vecs[4] = '{1, 9'h07F, 12'h7FE, 11};
        vecs[5] = '{2, 9'h07F, 12'h6FE, 11};
        vecs[6] = '{2, 9'h000, 12'h700, 11};
        vecs[7] = '{1, 9'h000, 12'h600, 11};
        vecs[8] = '{0, 9'h03C, 12'h278, 10};
        fillWords = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};

        total   = 0;
        bad     = 0;
        checkEn = 1'b0;
        resetN  = 1'b0;
        validW  = 3'b000;
        for (int d = 0; d < NDUT; d++) dataW[d] = '0;

        $display("[TB] reset and valid-during-reset");
        repeat (2) @(negedge clock);
        validW = 3'b111;
        for (int d = 0; d < NDUT; d++) dataW[d] = 9'h1AB;
        repeat (3) @(negedge clock);
        for (int d = 0; d < NDUT; d++)
            checkOutput($sformatf("reset outputs dut%0d", d), 32'(actVec(d)), 32'h900);
        validW = 3'b000;
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        for (int d = 0; d < NDUT; d++)
            checkOutput($sformatf("after release dut%0d", d), 32'(actVec(d)), 32'h900);
        checkEn = 1'b1;

        $display("[TB] single frames");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].dut, vecs[i].word);
            checkFrame(vecs[i].dut, vecs[i].expBits, vecs[i].expLen, $sformatf("vec%0d", i));
        end

        $display("[TB] fifo fill with held valid");
        doneTimes.delete();
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            validW[0] = 1'b1;
            dataW[0]  = fillWords[i];
            @(negedge clock);
            if (i == 4) begin
                checkOutput("fill ready after 5th edge", 32'(readyW[0]), 32'd0);
                checkOutput("fill count after 5th edge", 32'(getCount(0)), 32'd4);
            end
        end
        checkOutput("W5 rejected while full", 32'(getCount(0)), 32'd4);
        prevCount = getCount(0);
        changed   = 1'b0;
        for (int i = 0; i < 200 && !changed; i++) begin
            if (getCount(0) != prevCount) changed = 1'b1;
            else @(negedge clock);
        end
        checkOutput("full pop edge count", 32'(getCount(0)), 32'd3);
        checkOutput("full pop edge ready", 32'(readyW[0]), 32'd1);
        @(negedge clock);
        checkOutput("W5 accepted after pop", 32'(getCount(0)), 32'd4);
        validW[0] = 1'b0;
        repeat (530) @(negedge clock);
        checkOutput("fill done pulses", 32'(doneTimes.size()), 32'd6);
        for (int i = 1; i < doneTimes.size(); i++)
            checkOutput($sformatf("done spacing %0d", i), 32'(doneTimes[i] - doneTimes[i-1]), 32'(100 * PERIOD));

        $display("[TB] reset mid-frame");
        doneTimes.delete();
        applyStimulus(0, 9'h0C3);
        @(negedge clock);
        repeat (45) @(negedge clock);
        checkOutput("line during data bit 3", 32'(serialW[0]), 32'd0);
        #1 resetN = 1'b0;
        #1 checkOutput("outputs at mid-frame reset", 32'(actVec(0)), 32'h900);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        repeat (80) @(negedge clock);
        checkOutput("no done after truncated frame", 32'(doneTimes.size()), 32'd0);
        applyStimulus(0, 9'h03C);
        checkFrame(0, 12'h278, 10, "post-reset frame");

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int d = 0; d < NDUT; d++) begin
                validW[d] = ($urandom_range(0, 3) == 0);
                dataW[d]  = 9'($urandom);
            end
            @(negedge clock);
        end
        validW = 3'b000;
        repeat (2600) @(negedge clock);
        for (int d = 0; d < NDUT; d++)
            checkOutput($sformatf("drained dut%0d", d), 32'(actVec(d)), 32'h900);

        checkEn = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
